dmi_req_sync: RTL and testbench

DMI_REQ_SYNC -- requirements
Module: dmi_req_sync

---
 rtl/debug_pkg.sv | 37 +++
 rtl/dmi_req_sync_if.sv | 36 +++
 rtl/dmi_sync_cell.sv | 33 +++
 rtl/dmi_req_sync.sv | 151 +++++++++++++++
 tb/tb_dmi_req_sync.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared types and constants for the debug-module request path.
//               edge_mode_e selects which transition of a synchronized
//               request level counts as an event; edge_hit() applies it.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int SYNC_STAGES_MIN = 2;

  localparam int               OVR_CNT_W   = 8;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

  // Event qualifier: cur is the newest synchronized level, prev the level
  // one cycle earlier.
  function automatic logic edge_hit(edge_mode_e mode, logic cur, logic prev);
    logic hit;
    hit = 1'b0;
    unique case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage : debug_pkg
`default_nettype wire

// File: rtl/dmi_req_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : dmi_req_sync_if
// Description : Bundle between an asynchronous DMI request source and the
//               debug-module side of dmi_req_sync.
//   master : drives req_i, data_i, busy_i, ovr_clr_i; observes the rest
//   slave  : the synchronizer itself (receives req/data/busy/clear,
//            returns pulse_o, valid_o, data_o, ack_o, ovr_o, ovr_cnt_o)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmi_req_sync_if #(
  parameter int NCH = 2,
  parameter int DW  = 39
);
  logic [NCH-1:0] req_i;
  logic [DW-1:0]  data_i;
  logic           busy_i;
  logic           ovr_clr_i;
  logic [NCH-1:0] pulse_o;
  logic           valid_o;
  logic [DW-1:0]  data_o;
  logic [NCH-1:0] ack_o;
  logic           ovr_o;
  logic [7:0]     ovr_cnt_o;

  modport master (
    output req_i, data_i, busy_i, ovr_clr_i,
    input  pulse_o, valid_o, data_o, ack_o, ovr_o, ovr_cnt_o
  );

  modport slave (
    input  req_i, data_i, busy_i, ovr_clr_i,
    output pulse_o, valid_o, data_o, ack_o, ovr_o, ovr_cnt_o
  );
endinterface : dmi_req_sync_if
`default_nettype wire

// File: rtl/dmi_sync_cell.sv
`default_nettype none
// ============================================================================
// Module      : dmi_sync_cell
// Description : Multi-flop level synchronizer for one request bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : asynchronous level
//   q_o  : level after STAGES flops
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_sync_cell #(
  parameter int STAGES = 2
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : dmi_sync_cell
`default_nettype wire

// File: rtl/dmi_req_sync.sv
`default_nettype none
// ============================================================================
// Module      : dmi_req_sync
// Description : Brings asynchronous DMI request levels into the debug-module
//               clock domain, turns selected edges into one-hot single-cycle
//               strobes (lowest channel first, stalled by busy_i) and captures
//               the accompanying data bundle.
// Ports       :
//   clk            debug-module clock
//   rst            asynchronous active-high reset
//   bus (slave)    req_i/data_i/busy_i/ovr_clr_i in;
//                  pulse_o/valid_o/data_o/ack_o/ovr_o/ovr_cnt_o out
// Build option: DMI_SYNC_OVERRUN_EN - enables the sticky overrun flag and
//               saturating overrun counter; without it both read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_req_sync
  import debug_pkg::*;
#(
  parameter int         NCH         = 2,
  parameter int         SYNC_STAGES = 2,
  parameter int         DW          = 39,
  parameter edge_mode_e EDGE_MODE   = EDGE_RISE
) (
  input wire            clk,
  input wire            rst,
  dmi_req_sync_if.slave bus
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_chk_stages
    $error("dmi_req_sync: SYNC_STAGES=%0d below minimum %0d", SYNC_STAGES, SYNC_STAGES_MIN);
  end
  if (NCH < 1 || NCH > 8) begin : g_chk_nch
    $error("dmi_req_sync: NCH=%0d outside 1..8", NCH);
  end

  // After reset the chains need SYNC_STAGES edges to fill with the live
  // request level and one more for the history flop to follow. Events are
  // masked until then so a level already high at release is not an event.
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  logic [NCH-1:0]      sync_lvl;
  logic [NCH-1:0]      hist_q;
  logic [NCH-1:0]      evt;
  logic [NCH-1:0]      pending_q, pending_d;
  logic [NCH-1:0]      grant;
  logic [NCH-1:0]      pulse_q;
  logic [DW-1:0]       data_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                armed;
  logic                load;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    dmi_sync_cell #(
      .STAGES (SYNC_STAGES)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .d_i (bus.req_i[i]),
      .q_o (sync_lvl[i])
    );
  end

  assign armed = (settle_q == SETTLE_W'(SETTLE_MAX));

  always_comb begin
    evt = '0;
    for (int i = 0; i < NCH; i++) begin
      evt[i] = armed & edge_hit(EDGE_MODE, sync_lvl[i], hist_q[i]);
    end
  end

  // Isolate the lowest set pending bit; nothing is granted while busy.
  assign grant     = bus.busy_i ? '0 : (pending_q & (~pending_q + NCH'(1)));
  // A granted channel is consumed this cycle, so a fresh event on it re-arms.
  assign pending_d = (pending_q & ~grant) | evt;
  // Capture data only for the first request of an otherwise idle queue.
  assign load      = (|(evt & ~pending_q)) && (pending_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      data_q    <= '0;
      settle_q  <= '0;
    end else begin
      hist_q    <= sync_lvl;
      pending_q <= pending_d;
      pulse_q   <= grant;
      if (load) begin
        data_q <= bus.data_i;
      end
      if (!armed) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.valid_o = |pulse_q;
  assign bus.data_o  = data_q;
  assign bus.ack_o   = sync_lvl;

`ifdef DMI_SYNC_OVERRUN_EN
  logic                 overrun;
  logic                 ovr_q, ovr_d;
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

  assign overrun = |(evt & pending_q & ~grant);

  // An overrun coinciding with a clear restarts the count at one.
  always_comb begin
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (overrun) begin
      ovr_d = 1'b1;
      if (bus.ovr_clr_i) begin
        ovr_cnt_d = OVR_CNT_W'(1);
      end else if (ovr_cnt_q != OVR_CNT_MAX) begin
        ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
      end
    end else if (bus.ovr_clr_i) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign bus.ovr_o     = ovr_q;
  assign bus.ovr_cnt_o = ovr_cnt_q;
`else
  // Overruns merge silently; the clear input has no function in this build.
  logic unused_ovr_clr;
  assign unused_ovr_clr = bus.ovr_clr_i;
  assign bus.ovr_o      = 1'b0;
  assign bus.ovr_cnt_o  = '0;
`endif

endmodule : dmi_req_sync
`default_nettype wire

// File: tb/tb_dmi_req_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_req_sync
// Description : Self-checking bench for dmi_req_sync. Two instances share one
//               stimulus: rising-edge mode and both-edge mode. A reference
//               model schedules each request transition to land a fixed
//               number of edges later and then applies the queueing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_req_sync;
  import debug_pkg::*;

  localparam int NCH  = 2;
  localparam int DW   = 39;
  localparam int S    = 2;
  localparam int MAXC = 8192;
`ifdef DMI_SYNC_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req;
  logic [DW-1:0]  data;
  logic           busy;
  logic           clr;

  always #5 clk = ~clk;

  dmi_req_sync_if #(.NCH(NCH), .DW(DW)) bus_r ();
  dmi_req_sync_if #(.NCH(NCH), .DW(DW)) bus_b ();

  assign bus_r.req_i     = req;
  assign bus_r.data_i    = data;
  assign bus_r.busy_i    = busy;
  assign bus_r.ovr_clr_i = clr;
  assign bus_b.req_i     = req;
  assign bus_b.data_i    = data;
  assign bus_b.busy_i    = busy;
  assign bus_b.ovr_clr_i = clr;

  dmi_req_sync #(.NCH(NCH), .SYNC_STAGES(S), .DW(DW), .EDGE_MODE(EDGE_RISE)) u_rise (
    .clk (clk), .rst (rst), .bus (bus_r)
  );
  dmi_req_sync #(.NCH(NCH), .SYNC_STAGES(S), .DW(DW), .EDGE_MODE(EDGE_BOTH)) u_both (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // ---------------- reference model ----------------
  logic [NCH-1:0] ev_at  [2][MAXC];   // events landing at a given edge number
  logic [NCH-1:0] req_at [MAXC];      // request level present at each edge
  logic           rst_at [MAXC];
  logic [NCH-1:0] pend_m [2];
  logic [NCH-1:0] pulse_m[2];
  logic [DW-1:0]  data_m [2];
  logic           ovr_m  [2];
  int             cnt_m  [2];
  int             cyc;
  int             tests;
  int             fails;

  function automatic edge_mode_e mode_of(int d);
    return (d == 0) ? EDGE_RISE : EDGE_BOTH;
  endfunction

  function automatic logic hit(edge_mode_e m, logic now, logic was);
    if (m == EDGE_RISE) return now && !was;
    if (m == EDGE_FALL) return !now && was;
    return now != was;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend_m[d] = '0; pulse_m[d] = '0; data_m[d] = '0; ovr_m[d] = 1'b0; cnt_m[d] = 0;
      for (int k = cyc + 1; k < MAXC; k++) ev_at[d][k] = '0;
    end
  endtask

  // A transition driven after edge cyc is captured at cyc+1, leaves the
  // synchronizer at cyc+S and becomes pending at edge cyc+S+1.
  task automatic drive_req(input logic [NCH-1:0] nv);
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++)
        if (hit(mode_of(d), nv[ch], req[ch]) && (cyc + S + 1 < MAXC))
          ev_at[d][cyc + S + 1][ch] = 1'b1;
    req = nv;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async.pulse_r", 64'(bus_r.pulse_o), 64'd0);
    chk("rst_async.valid_r", 64'(bus_r.valid_o), 64'd0);
    chk("rst_async.data_r",  64'(bus_r.data_o),  64'd0);
    chk("rst_async.ack_r",   64'(bus_r.ack_o),   64'd0);
    chk("rst_async.ovr_r",   64'(bus_r.ovr_o),   64'd0);
    chk("rst_async.cnt_r",   64'(bus_r.ovr_cnt_o), 64'd0);
    chk("rst_async.pulse_b", 64'(bus_b.pulse_o), 64'd0);
    chk("rst_async.data_b",  64'(bus_b.data_o),  64'd0);
  endtask

  task automatic tick();
    int             e;
    logic [NCH-1:0] g, ev, ack_exp;
    logic           ovr_hit, ack_ok;
    logic [NCH-1:0] o_pulse, o_ack;
    logic           o_valid, o_ovr;
    logic [DW-1:0]  o_data;
    logic [7:0]     o_cnt;
    string          nm;
    e = cyc + 1;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d required<%0d", e, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    req_at[e] = req;
    rst_at[e] = rst;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend_m[d] = '0; pulse_m[d] = '0; data_m[d] = '0; ovr_m[d] = 1'b0; cnt_m[d] = 0;
      end else begin
        g = '0;
        if (!busy)
          for (int ch = 0; ch < NCH; ch++)
            if (pend_m[d][ch] && g == '0) g[ch] = 1'b1;
        ev      = ev_at[d][e];
        ovr_hit = |(ev & pend_m[d] & ~g);
        if ((ev & ~pend_m[d]) != '0 && pend_m[d] == '0) data_m[d] = data;
        pend_m[d]  = (pend_m[d] & ~g) | ev;
        pulse_m[d] = g;
        if (OVR_EN) begin
          if (ovr_hit) begin
            ovr_m[d] = 1'b1;
            cnt_m[d] = clr ? 1 : ((cnt_m[d] < 255) ? cnt_m[d] + 1 : 255);
          end else if (clr) begin
            ovr_m[d] = 1'b0;
            cnt_m[d] = 0;
          end
        end
      end
    end
    @(posedge clk);
    cyc = e;
    #1;
    // Synchronized level is the request present S-1 edges ago, provided no
    // reset touched the chain since.
    ack_ok = !rst && (e - S + 1 >= 1);
    if (ack_ok)
      for (int k = e - S + 1; k <= e; k++) if (rst_at[k]) ack_ok = 1'b0;
    ack_exp = ack_ok ? req_at[e - S + 1] : '0;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_pulse = bus_r.pulse_o; o_valid = bus_r.valid_o; o_data = bus_r.data_o;
        o_ack = bus_r.ack_o; o_ovr = bus_r.ovr_o; o_cnt = bus_r.ovr_cnt_o; nm = "rise";
      end else begin
        o_pulse = bus_b.pulse_o; o_valid = bus_b.valid_o; o_data = bus_b.data_o;
        o_ack = bus_b.ack_o; o_ovr = bus_b.ovr_o; o_cnt = bus_b.ovr_cnt_o; nm = "both";
      end
      chk($sformatf("%s.pulse@%0d", nm, cyc), 64'(o_pulse), 64'(pulse_m[d]));
      chk($sformatf("%s.valid@%0d", nm, cyc), 64'(o_valid), 64'(pulse_m[d] != '0));
      chk($sformatf("%s.data@%0d",  nm, cyc), 64'(o_data),  64'(data_m[d]));
      chk($sformatf("%s.ack@%0d",   nm, cyc), 64'(o_ack),   64'(ack_exp));
      chk($sformatf("%s.ovr@%0d",   nm, cyc), 64'(o_ovr),   64'(ovr_m[d]));
      chk($sformatf("%s.cnt@%0d",   nm, cyc), 64'(o_cnt),   64'(cnt_m[d]));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] nv;
    logic [DW-1:0]  dsave;
    rst = 1'b1; req = '0; data = '0; busy = 1'b0; clr = 1'b0;
    cyc = 0; tests = 0; fails = 0;
    for (int k = 0; k < MAXC; k++) begin
      ev_at[0][k] = '0; ev_at[1][k] = '0; req_at[k] = '0; rst_at[k] = 1'b0;
    end
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("reset.pulse", 64'(bus_r.pulse_o), 64'd0);
    chk("reset.data",  64'(bus_r.data_o),  64'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single read request: strobe exactly S+2 edges after the transition
    data = 39'h12_DEADBEEF;
    drive_req(2'b01);
    repeat (3) begin
      tick();
      chk("lat.early_pulse", 64'(bus_r.pulse_o), 64'd0);
    end
    tick();
    chk("lat.pulse", 64'(bus_r.pulse_o), 64'd1);
    chk("lat.data",  64'(bus_r.data_o),  64'h12_DEADBEEF);
    chk("lat.ack0",  64'(bus_r.ack_o[0]), 64'd1);
    tick();
    chk("lat.single", 64'(bus_r.pulse_o), 64'd0);
    drive_req(2'b00);
    repeat (6) tick();

    // Simultaneous requests: ascending strobes, one data capture
    dsave = DW'({$urandom(), $urandom()});
    data  = dsave;
    drive_req(2'b11);
    repeat (4) tick();
    chk("simul.first",  64'(bus_r.pulse_o), 64'd1);
    chk("simul.data1",  64'(bus_r.data_o),  64'(dsave));
    data = DW'({$urandom(), $urandom()});
    tick();
    chk("simul.second", 64'(bus_r.pulse_o), 64'd2);
    chk("simul.data2",  64'(bus_r.data_o),  64'(dsave));
    drive_req(2'b00);
    repeat (6) tick();

    // Busy stall: ten busy cycles around an event
    busy = 1'b1;
    repeat (3) tick();
    data = DW'({$urandom(), $urandom()});
    drive_req(2'b01);
    repeat (7) begin
      tick();
      chk("busy.held", 64'(bus_r.pulse_o), 64'd0);
    end
    busy = 1'b0;
    tick();
    chk("busy.release", 64'(bus_r.pulse_o), 64'd1);
    drive_req(2'b00);
    repeat (6) tick();

    // Both-edge mode: two toggles on ch1 while busy merge into one strobe
    clr = 1'b1; tick(); clr = 1'b0;
    busy = 1'b1;
    drive_req(2'b10);
    repeat (2) tick();
    drive_req(2'b00);
    repeat (4) tick();
    chk("both.ovr", 64'(bus_b.ovr_o),     64'(OVR_EN));
    chk("both.cnt", 64'(bus_b.ovr_cnt_o), OVR_EN ? 64'd1 : 64'd0);
    busy = 1'b0;
    tick();
    chk("both.pulse",  64'(bus_b.pulse_o), 64'd2);
    tick();
    chk("both.single", 64'(bus_b.pulse_o), 64'd0);
    repeat (4) tick();

    // Counter saturation: 300 overruns on ch0 while busy
    clr = 1'b1; tick(); clr = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 301; i++) begin
      drive_req(2'b01); tick();
      drive_req(2'b00); tick();
    end
    repeat (5) tick();
    chk("sat.cnt_r", 64'(bus_r.ovr_cnt_o), OVR_EN ? 64'd255 : 64'd0);
    chk("sat.ovr_r", 64'(bus_r.ovr_o),     64'(OVR_EN));
    busy = 1'b0;
    tick();
    chk("sat.pulse", 64'(bus_r.pulse_o), 64'd1);
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("sat.clr_cnt", 64'(bus_r.ovr_cnt_o), 64'd0);
    chk("sat.clr_ovr", 64'(bus_r.ovr_o),     64'd0);

    // Randomized traffic against the model
    repeat (500) begin
      if ($urandom_range(0, 99) < 35) begin
        nv   = req ^ NCH'(1 << $urandom_range(0, NCH - 1));
        data = DW'({$urandom(), $urandom()});
        drive_req(nv);
      end
      busy = ($urandom_range(0, 99) < 30);
      clr  = ($urandom_range(0, 99) < 4);
      tick();
    end
    busy = 1'b0; clr = 1'b0;
    repeat (10) tick();

    // Reset one cycle after a request edge: nothing may ever strobe
    drive_req(2'b00);
    repeat (8) tick();
    data = DW'({$urandom(), $urandom()});
    drive_req(2'b01);
    tick();
    assert_rst();
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      chk("rstmid.pulse_r", 64'(bus_r.pulse_o), 64'd0);
      chk("rstmid.pulse_b", 64'(bus_b.pulse_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dmi_req_sync
`default_nettype wire
